// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared constants and FSM encodings for the pipeline sequencer
package pipeline_pkg;

  localparam int NB_STATE = 3;
  localparam int N_DRAIN  = 3;

  // Opcode field value that the decoder reports as HALT
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [NB_STATE-1:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

endpackage

// File: rtl/hazard_detection_unit.sv
// rtl/hazard_detection_unit.sv - load-use hazard detection between EX and ID
module hazard_detection_unit #(
  parameter int NB_REG = 5
) (
  input  logic              ex_mem_read,
  input  logic [NB_REG-1:0] ex_rt,
  input  logic [NB_REG-1:0] id_rs,
  input  logic [NB_REG-1:0] id_rt,
  output logic              stall
);

  // $zero is never a real dependency, so a load into r0 cannot stall
  assign stall = ex_mem_read && (ex_rt != '0) &&
                 ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - run/step FSM with stall, flush and HALT drain control
module pipeline_sequencer #(
  parameter int NB_REG    = 5,
  parameter int NB_CYCLES = 32,
  parameter int N_DRAIN   = 3,
  parameter int NB_STATE  = 3
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_du_run,
  input  logic                 i_du_step,
  input  logic                 i_du_pause,
  input  logic                 i_EX_mem_read,
  input  logic [NB_REG-1:0]    i_EX_rt,
  input  logic [NB_REG-1:0]    i_ID_rs,
  input  logic [NB_REG-1:0]    i_ID_rt,
  input  logic                 i_branch_taken,
  input  logic                 i_ID_halt,
  output logic                 o_pipe_enable,
  output logic                 o_pc_write,
  output logic                 o_IF_ID_write,
  output logic                 o_IF_ID_flush,
  output logic                 o_ID_EX_bubble,
  output logic                 o_halted,
  output logic [NB_STATE-1:0]  o_state,
  output logic [NB_CYCLES-1:0] o_cycle_count
);

  import pipeline_pkg::state_e;
  import pipeline_pkg::ST_IDLE;
  import pipeline_pkg::ST_RUN;
  import pipeline_pkg::ST_STEP;
  import pipeline_pkg::ST_DRAIN;
  import pipeline_pkg::ST_HALTED;

  localparam int NB_DRAIN = (N_DRAIN > 1) ? $clog2(N_DRAIN) : 1;
  localparam logic [NB_DRAIN-1:0] DRAIN_LAST = NB_DRAIN'(N_DRAIN - 1);

  state_e                state, next_state;
  logic                  m_step, next_m_step;
  logic [NB_DRAIN-1:0]   drain_cnt, next_drain_cnt;
  logic [NB_CYCLES-1:0]  cycle_count;

  logic en, raw_stall, stall, flush, halt_hit, draining;

  hazard_detection_unit #(.NB_REG(NB_REG)) u_hazard (
    .ex_mem_read (i_EX_mem_read),
    .ex_rt       (i_EX_rt),
    .id_rs       (i_ID_rs),
    .id_rt       (i_ID_rt),
    .stall       (raw_stall)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state       <= ST_IDLE;
      m_step      <= 1'b0;
      drain_cnt   <= '0;
      cycle_count <= '0;
    end else begin
      state     <= next_state;
      m_step    <= next_m_step;
      drain_cnt <= next_drain_cnt;
      if (en && (cycle_count != '1))
        cycle_count <= cycle_count + NB_CYCLES'(1);
    end
  end

  always_comb begin
    en = 1'b0;
    case (state)
      ST_RUN:   en = 1'b1;
      ST_STEP:  en = i_du_step;
      ST_DRAIN: en = m_step ? i_du_step : 1'b1;
      default:  en = 1'b0;
    endcase
  end

  // A taken branch squashes whatever sits in ID, including a HALT
  assign stall    = en && raw_stall;
  assign flush    = en && i_branch_taken;
  assign draining = (state == ST_DRAIN);
  assign halt_hit = en && i_ID_halt && !flush &&
                    ((state == ST_RUN) || (state == ST_STEP));

  assign o_pipe_enable  = en;
  assign o_pc_write     = !draining && en && (flush || (!stall && !halt_hit));
  assign o_IF_ID_write  = (en && !stall) || flush;
  assign o_IF_ID_flush  = flush || halt_hit || (draining && en);
  assign o_ID_EX_bubble = stall || flush;
  assign o_halted       = (state == ST_HALTED);
  assign o_state        = NB_STATE'(state);
  assign o_cycle_count  = cycle_count;

  always_comb begin
    next_state     = state;
    next_m_step    = m_step;
    next_drain_cnt = drain_cnt;
    case (state)
      ST_IDLE: begin
        if (i_du_run) begin
          next_state  = ST_RUN;
          next_m_step = 1'b0;
        end else if (i_du_step) begin
          next_state  = ST_STEP;
          next_m_step = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt_hit) begin
          next_state     = ST_DRAIN;
          next_drain_cnt = DRAIN_LAST;
        end else if (i_du_pause) begin
          next_state = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (i_du_run)
          next_m_step = 1'b0;
        if (halt_hit) begin
          next_state     = ST_DRAIN;
          next_drain_cnt = DRAIN_LAST;
        end else if (i_du_run) begin
          next_state = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (en) begin
          if (drain_cnt == '0)
            next_state = ST_HALTED;
          else
            next_drain_cnt = drain_cnt - NB_DRAIN'(1);
        end
      end
      default: ;
    endcase
  end

endmodule
